// File: rtl/md_defs_pkg.sv
// ---------------------------------------------------------------------------
// md_defs : shared definitions for the multiply/divide unit.
//   - md_op_t    : operation encodings on the op bus (MADD/MSUB are live only
//                  when the MDU_MADD_EN macro is defined)
//   - md_state_t : IDLE/RUN control state
//   - default busy-cycle counts and the cycle-counter width
// The instruction decoder imports this package to drive op.
// ---------------------------------------------------------------------------
package md_defs;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MSUB  = 3'd7
    } md_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_t;

    // Cycle counts are limited to 1..15 so they fit the 4-bit counter.
    localparam int unsigned MD_CNT_W           = 4;
    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_counter.sv
// ---------------------------------------------------------------------------
// md_counter : loadable down-counter with a terminal-count flag.
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset (count -> 0)
//   i_load     in   load i_load_val (has priority over decrement)
//   i_load_val in   W-bit load value
//   i_dec      in   decrement by one; saturates at zero
//   o_tc       out  high while the count equals 1 (last busy cycle)
// ---------------------------------------------------------------------------
module md_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit : multi-cycle multiply/divide unit holding the HI/LO registers.
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset
//   start        in   launch the operation on op (sampled at rising edge)
//   op           in   md_op_t encoding (MULT/MULTU/DIV/DIVU/MTHI/MTLO/MADD/MSUB)
//   a, b         in   rs / rt operands
//   busy         out  operation in flight; hi/lo still hold pre-op values
//   hi, lo       out  architectural HI/LO registers
//   o_dbg_state  out  current control state (IDLE/RUN)
//
// Handshake: start is accepted only when busy=0. A long op (MULT/MULTU/DIV/
// DIVU, MADD/MSUB when enabled) raises busy from the next cycle for exactly
// MULT_CYCLES or DIV_CYCLES cycles; the result lands in hi/lo on the edge
// that drops busy. MTHI/MTLO complete in one edge without raising busy.
// Any start seen while busy=1 is dropped.
//
// Optional macro MDU_MADD_EN enables MADD/MSUB ({hi,lo} +/- signed a*b);
// otherwise op 6/7 are no-ops.
// ---------------------------------------------------------------------------
module mult_div_unit
    import md_defs::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,  // 1..15
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF    // 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output md_state_t   o_dbg_state
);

    md_state_t r_state;
    md_state_t w_state_nxt;
    md_op_t    r_op;
    md_op_t    w_op;
    logic [31:0] r_a, r_b, r_hi, r_lo;
    logic [31:0] w_hi_nxt, w_lo_nxt;
    logic        w_launch;
    logic [MD_CNT_W-1:0] w_load_val;
    logic        w_tc;

    // Result datapath, purely combinational from the latched operands.
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic [31:0]        w_sden, w_uden;
    logic signed [31:0] w_sq, w_sr;
    logic [31:0]        w_uq, w_ur;
    logic [63:0]        w_res;
    logic               w_res_we;

    assign w_op = md_op_t'(op);

    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Divisor of 1 for b=0 keeps the dividers defined (result is discarded).
    // For 0x80000000 / -1 a divisor of 1 yields exactly q=0x80000000, r=0.
    assign w_sden = ((r_b == 32'd0) || ((r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF)))
                    ? 32'd1 : r_b;
    assign w_uden = (r_b == 32'd0) ? 32'd1 : r_b;

    // SV signed / and % truncate toward zero; remainder takes dividend sign.
    assign w_sq = $signed(r_a) / $signed(w_sden);
    assign w_sr = $signed(r_a) % $signed(w_sden);
    assign w_uq = r_a / w_uden;
    assign w_ur = r_a % w_uden;

    always_comb begin
        w_res_we = 1'b0;
        w_res    = {r_hi, r_lo};
        case (r_op)
            MD_MULT: begin
                w_res_we = 1'b1;
                w_res    = w_prod_s;
            end
            MD_MULTU: begin
                w_res_we = 1'b1;
                w_res    = w_prod_u;
            end
            MD_DIV: begin
                w_res_we = (r_b != 32'd0);
                w_res    = {w_sr, w_sq};
            end
            MD_DIVU: begin
                w_res_we = (r_b != 32'd0);
                w_res    = {w_ur, w_uq};
            end
`ifdef MDU_MADD_EN
            // hi/lo are frozen during RUN, so they still hold the base value
            // captured at the start edge.
            MD_MADD: begin
                w_res_we = 1'b1;
                w_res    = {r_hi, r_lo} + w_prod_s;
            end
            MD_MSUB: begin
                w_res_we = 1'b1;
                w_res    = {r_hi, r_lo} - w_prod_s;
            end
`endif
            default: ;
        endcase
    end

    // Next-state / HI-LO update logic.
    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_load_val  = MD_CNT_W'(MULT_CYCLES);
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            IDLE: begin
                if (start) begin
                    case (w_op)
                        MD_MULT, MD_MULTU: begin
                            w_launch   = 1'b1;
                            w_load_val = MD_CNT_W'(MULT_CYCLES);
                        end
                        MD_DIV, MD_DIVU: begin
                            w_launch   = 1'b1;
                            w_load_val = MD_CNT_W'(DIV_CYCLES);
                        end
                        MD_MTHI: w_hi_nxt = a;
                        MD_MTLO: w_lo_nxt = a;
`ifdef MDU_MADD_EN
                        MD_MADD, MD_MSUB: begin
                            w_launch   = 1'b1;
                            w_load_val = MD_CNT_W'(MULT_CYCLES);
                        end
`endif
                        default: ;
                    endcase
                end
                if (w_launch) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_tc) begin
                    w_state_nxt = IDLE;
                    if (w_res_we) begin
                        {w_hi_nxt, w_lo_nxt} = w_res;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
            r_a  <= 32'd0;
            r_b  <= 32'd0;
            r_op <= MD_MULT;
        end else begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (w_launch) begin
                r_a  <= a;
                r_b  <= b;
                r_op <= w_op;
            end
        end
    end

    md_counter #(
        .W (MD_CNT_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_launch),
        .i_load_val (w_load_val),
        .i_dec      (r_state == RUN),
        .o_tc       (w_tc)
    );

    assign busy        = (r_state == RUN);
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit : directed self-checking bench for mult_div_unit.
// Expected values are hand-computed constants. Honours MDU_MADD_EN.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
    import md_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy;
    logic [31:0] hi, lo;
    md_state_t   dbg_state;

    int checks = 0;
    int errors = 0;
    int n;

    mult_div_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .hi          (hi),
        .lo          (lo),
        .o_dbg_state (dbg_state)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Driver / checker tasks
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse; returns at the negedge after the start edge.
    task automatic issue(input logic [2:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b);
        @(negedge clk);
        start = 1'b1;
        op    = t_op;
        a     = t_a;
        b     = t_b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedge samples with busy=1, bounded.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_state", {31'd0, dbg_state}, {31'd0, IDLE});
        reset = 1'b0;

        // MTHI / MTLO: single edge, no busy
        issue(MD_MTHI, 32'h0000_1234, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h0000_1234);
        issue(MD_MTLO, 32'h0000_5678, 32'd0);
        chk("mtlo_lo", lo, 32'h0000_5678);
        chk("mtlo_hi_kept", hi, 32'h0000_1234);

        // MULT -2*3 with hold checks, ignored MTHI and operand change mid-run
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        chk("mult_busy_on", {31'd0, busy}, 32'd1);
        chk("mult_state_run", {31'd0, dbg_state}, {31'd0, RUN});
        chk("mult_hold_hi", hi, 32'h0000_1234);
        chk("mult_hold_lo", lo, 32'h0000_5678);
        start = 1'b1;
        op    = MD_MTHI;
        a     = 32'hDEAD_BEEF;
        b     = 32'd0;
        @(negedge clk);
        start = 1'b0;
        chk("mult_busy_mthi_ign", hi, 32'h0000_1234);
        wait_idle(n);
        chk("mult_cycles", 32'(n + 1), 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU max*max
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("multu_cycles", 32'(n), 32'd5);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        // MULT 0x7FFFFFFF * 0x80000000 = -(2^62 - 2^31)
        issue(MD_MULT, 32'h7FFF_FFFF, 32'h8000_0000);
        wait_idle(n);
        chk("mult_big_hi", hi, 32'hC000_0000);
        chk("mult_big_lo", lo, 32'h8000_0000);

        // DIV -7/2
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        chk("div_cycles", 32'(n), 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU 100/7
        issue(MD_DIVU, 32'd100, 32'd7);
        wait_idle(n);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        // DIV overflow
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0000_0000);

        // DIVU by zero: full busy, hi/lo unchanged
        issue(MD_MTHI, 32'h11, 32'd0);
        issue(MD_MTLO, 32'h22, 32'd0);
        issue(MD_DIVU, 32'd100, 32'd0);
        wait_idle(n);
        chk("divz_cycles", 32'(n), 32'd10);
        chk("divz_hi", hi, 32'h11);
        chk("divz_lo", lo, 32'h22);

        // MADD / MSUB (or no-op without the macro)
        issue(MD_MTHI, 32'h0, 32'd0);
        issue(MD_MTLO, 32'hFFFF_FFFF, 32'd0);
        issue(MD_MADD, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        wait_idle(n);
        chk("madd_cycles", 32'(n), 32'd5);
        chk("madd_hi", hi, 32'h1);
        chk("madd_lo", lo, 32'h0);
        issue(MD_MSUB, 32'd1, 32'd1);
        wait_idle(n);
        chk("msub_cycles", 32'(n), 32'd5);
        chk("msub_hi", hi, 32'h0);
        chk("msub_lo", lo, 32'hFFFF_FFFF);
`else
        chk("madd_off_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        chk("madd_off_busy_late", {31'd0, busy}, 32'd0);
        chk("madd_off_hi", hi, 32'h0);
        chk("madd_off_lo", lo, 32'hFFFF_FFFF);
`endif

        // Reset mid-operation; MTLO during busy must be ignored
        issue(MD_MTHI, 32'h77, 32'd0);
        issue(MD_MTLO, 32'h88, 32'd0);
        issue(MD_MULT, 32'd3, 32'd4);
        @(negedge clk);
        start = 1'b1;
        op    = MD_MTLO;
        a     = 32'h55;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        chk("abort_mtlo_ign", lo, 32'h88);
        reset = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        chk("abort_state", {31'd0, dbg_state}, {31'd0, IDLE});
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort_busy_late", {31'd0, busy}, 32'd0);
        chk("abort_hi_late", hi, 32'd0);
        chk("abort_lo_late", lo, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit for the pipelined MIPS core. Sits in the EX stage beside the ALU.
- Holds the architectural HI/LO registers.
- Its hi/lo outputs feed the EX/MEM result-select mux, which picks among ALU, HI, LO and PC+8.
- Its busy output feeds the hazard unit, which stalls any MD-class instruction while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD-family when enabled); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launch the operation in op; sampled on rising clk edge.
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6=MADD 7=MSUB (6/7 only under the macro).
- a  input  32  operand rs.
- b  input  32  operand rt.
- busy  output  1  operation in flight; HI/LO not yet valid.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset is asynchronous and active-high: busy=0, hi=0, lo=0, counter=0, state=IDLE.
- States: IDLE, RUN.
- IDLE:
  - start with op in 0..3: latch a, b and op; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN. busy=1 from the next cycle.
  - start with op=4: hi<=a next edge; no busy.
  - start with op=5: lo<=a next edge; no busy.
  - op 6/7 without the macro: no-op.
- RUN:
  - Counter decrements each cycle.
  - In the cycle the counter reaches 1, hi/lo are written with the result. busy drops at the same edge, so busy is high for exactly N cycles.
  - New hi/lo are visible the first cycle busy=0.
- start while busy=1 is ignored, including MTHI/MTLO. The hazard unit guarantees this never happens; the bench checks it anyway.
- hi/lo hold their old values throughout RUN. A read during RUN returns the pre-operation values.
- Result computed from latched operands; a/b changing mid-run has no effect.
- MULT: {hi,lo} = signed a * signed b, full 64-bit.
- MULTU: {hi,lo} = unsigned 64-bit product.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (b=0, DIV/DIVU): full busy period runs; hi/lo left unchanged.
- DIV overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Reset asserted mid-operation aborts immediately: busy=0, hi=lo=0, and no result is written afterwards.
- Result arithmetic may be combinational from the latched operands; only the timing is multi-cycle.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - op 6 (MADD): {hi,lo} <= {hi,lo} + signed a*b, mod 2^64.
  - op 7 (MSUB): {hi,lo} <= {hi,lo} - signed a*b, mod 2^64.
  - Both use MULT_CYCLES.
  - The accumulator base is the {hi,lo} value at the start edge.
- Not defined: ops 6/7 are no-ops; busy stays 0 and hi/lo are unchanged.

Decomposition:
- Shared package/header md_defs:
  - op encodings MD_MULT..MD_MSUB;
  - state encodings IDLE/RUN;
  - default cycle counts.
- The decoder also uses md_defs to drive op.
- One natural sub-module: md_counter (loadable down-counter with a terminal-count flag). Everything else stays in mult_div_unit.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=100, b=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- MULT 3*4 started; MTLO a=0x55 pulsed at busy cycle 2; reset asserted at busy cycle 3 -> MTLO ignored; busy=0 and hi=lo=0 immediately; no write after reset.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADD a=1, b=1 -> hi=1, lo=0. Without the macro, same stimulus -> busy never rises; hi/lo unchanged.
